// File: rtl/cipher_msg_loader.sv
// ---------------------------------------------------------------------------
// cipher_msg_loader
//
// Collects a ciphertext message from a byte stream into a 256-byte buffer.
// The buffer is presented flat to the decryptor's ct_mem. A complete message
// is held stable until the decryption stage frees it. Freeing the buffer
// scrubs only the bytes that were written, which is enough to keep every
// byte at or beyond the current write index at 0x00.
//
// Ports
//   clk             system clock; all state changes on its rising edge
//   reset           asynchronous, active-low clear of all state and buffer
//   in_valid        upstream byte present
//   in_byte         ciphertext byte, stored unmodified
//   in_last         in_byte is the final byte of the message
//   in_ready        a byte can be accepted this cycle (IDLE or LOAD)
//   buf_release     one-cycle pulse from the decryption stage's okay
//                   handshake; frees the buffer when a message is held
//   ct_flat         buffer image, byte i on bits [8i+7:8i]
//   msg_length_byte number of valid bytes in the buffer
//   msg_valid       buffer holds a complete, stable message
//   overflow        sticky flag: message was truncated at MAX_LEN bytes
//
// Parameter
//   MAX_LEN         maximum bytes per message, 1..255
// ---------------------------------------------------------------------------
module cipher_msg_loader #(
    parameter int MAX_LEN = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          buf_release,
    output logic [2047:0] ct_flat,
    output logic [7:0]    msg_length_byte,
    output logic          msg_valid,
    output logic          overflow
);

    // Index of the last byte that may be stored before truncation.
    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] wr_ptr;
    logic [7:0] clr_ptr;
    logic [7:0] buf_mem [256];
    logic       xfer;
    logic       end_of_msg;
    logic       clr_done;

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign xfer     = in_valid && in_ready;

    // A transfer closes the message either on in_last or when the buffer
    // limit is reached; the latter is the truncation case.
    assign end_of_msg = in_last || (wr_ptr == LAST_IDX);

    // Last scrub cycle: clr_ptr has reached the final written byte.
    assign clr_done = (clr_ptr == (msg_length_byte - 8'd1));

    for (genvar g = 0; g < 256; g++) begin : g_flat
        assign ct_flat[8*g +: 8] = buf_mem[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= 8'd0;
            clr_ptr         <= 8'd0;
            msg_length_byte <= 8'd0;
            msg_valid       <= 1'b0;
            overflow        <= 1'b0;
            for (int i = 0; i < 256; i++) begin
                buf_mem[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        buf_mem[wr_ptr] <= in_byte;
                        wr_ptr          <= wr_ptr + 8'd1;
                        if (end_of_msg) begin
                            state           <= HOLD;
                            msg_length_byte <= wr_ptr + 8'd1;
                            msg_valid       <= 1'b1;
                            // Only a limit hit without in_last is a truncation.
                            overflow        <= !in_last;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                HOLD: begin
                    // Buffer, length and overflow stay frozen; input ignored.
                    if (buf_release) begin
                        state     <= CLEAR;
                        clr_ptr   <= 8'd0;
                        msg_valid <= 1'b0;
                    end
                end

                CLEAR: begin
                    buf_mem[clr_ptr] <= 8'h00;
                    if (clr_done) begin
                        state           <= IDLE;
                        wr_ptr          <= 8'd0;
                        clr_ptr         <= 8'd0;
                        msg_length_byte <= 8'd0;
                        overflow        <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_msg_loader.sv
module tb_cipher_msg_loader;

    localparam int MAX_LEN = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          buf_release = 1'b0;
    logic [2047:0] ct_flat;
    logic [7:0]    msg_length_byte;
    logic          msg_valid;
    logic          overflow;

    cipher_msg_loader #(.MAX_LEN(MAX_LEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_byte         (in_byte),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .buf_release     (buf_release),
        .ct_flat         (ct_flat),
        .msg_length_byte (msg_length_byte),
        .msg_valid       (msg_valid),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] data;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] exp_mem [256];
    logic [7:0] msg_buf [300];
    int         m_idx;
    bit         m_done;

    typedef struct {
        int         msg_sel;
        int         nbytes;
        bit         with_last;
        bit         toggle;
        int         exp_len;
        bit         exp_ovf;
        int         probe_idx;
        logic [7:0] probe_val;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_buf(input string name);
        int first_bad;
        first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (first_bad < 0 && ct_flat[8*i +: 8] !== exp_mem[i]) first_bad = i;
        end
        n_checks++;
        if (first_bad >= 0) begin
            n_fail++;
            $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h", name, first_bad,
                     ct_flat[8*first_bad +: 8], exp_mem[first_bad]);
        end
    endtask

    task automatic load_msg(input int sel);
        string s;
        for (int i = 0; i < 300; i++) msg_buf[i] = 8'h00;
        case (sel)
            0: s = "Wkh txlfn eurzq ira mxpsv ryhu wkh odcb grj";
            1: s = "Zngbh Fnxhen vf gur orfg tveym";
            default: s = "";
        endcase
        if (sel == 2) begin
            for (int i = 0; i < 300; i++) msg_buf[i] = 8'((i * 37 + 11) & 255);
        end else if (sel == 3) begin
            msg_buf[0] = 8'h51;
        end else begin
            for (int i = 0; i < s.len(); i++) msg_buf[i] = s[i];
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_done = 1'b0;
        sb_q.delete();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last);
        @(negedge clk);
        chk("msg_valid_timing", msg_valid, m_done);
        chk("in_ready", in_ready, !m_done);
        in_valid    = 1'b1;
        in_byte     = b;
        in_last     = last;
        buf_release = 1'b0;
        if (!m_done) begin
            sb_q.push_back({8'(m_idx), b});
            exp_mem[m_idx] = b;
            m_idx++;
            if (last || m_idx == MAX_LEN) m_done = 1'b1;
        end
    endtask

    // Idle cycle inside a message: in_valid low with junk data, in_last and a
    // stray release, none of which may have any effect while loading.
    task automatic drive_gap();
        @(negedge clk);
        chk("msg_valid_gap", msg_valid, m_done);
        chk("in_ready_gap", in_ready, !m_done);
        in_valid    = 1'b0;
        in_byte     = 8'hEE;
        in_last     = 1'b1;
        buf_release = 1'b1;
    endtask

    task automatic send(input int start, input int n, input bit with_last, input bit toggle);
        for (int i = start; i < n; i++) begin
            drive_byte(msg_buf[i], with_last && (i == n - 1));
            if (toggle && i < n - 1) drive_gap();
        end
        @(negedge clk);
        chk("msg_valid_end", msg_valid, m_done);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_byte     = 8'h00;
        buf_release = 1'b0;
    endtask

    task automatic drain_sb();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("buf[%0d]", e.idx), ct_flat[8*int'(e.idx) +: 8], e.data);
        end
    endtask

    task automatic tail_zero(input int len);
        int nz;
        nz = 0;
        for (int i = len; i < 256; i++) if (ct_flat[8*i +: 8] !== 8'h00) nz++;
        chk("tail_zero", nz, 0);
    endtask

    task automatic release_and_clear(input int exp_cycles);
        int n;
        @(negedge clk);
        buf_release = 1'b1;
        in_valid    = 1'b0;
        @(negedge clk);
        buf_release = 1'b0;
        chk("msg_valid_in_clear", msg_valid, 1'b0);
        n = 0;
        while (in_ready !== 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, exp_cycles);
        clear_exp();
        chk_buf("buf_after_clear");
        chk("len_after_clear", msg_length_byte, 0);
        chk("ovf_after_clear", overflow, 0);
        chk("in_ready_after_clear", in_ready, 1);
        chk("msg_valid_after_clear", msg_valid, 0);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,  43, 1'b1, 1'b0,  43, 1'b0,   0, 8'h57};
        vecs[1] = '{0,  43, 1'b1, 1'b1,  43, 1'b0,  42, 8'h6A};
        vecs[2] = '{1,  29, 1'b1, 1'b0,  29, 1'b0,   0, 8'h5A};
        vecs[3] = '{2, 300, 1'b0, 1'b0, 255, 1'b1, 254, 8'hC1};
        vecs[4] = '{3,   1, 1'b1, 1'b0,   1, 1'b0,   0, 8'h51};

        clear_exp();
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk_buf("buf_in_reset");
        chk("len_in_reset", msg_length_byte, 0);
        chk("msg_valid_in_reset", msg_valid, 0);
        chk("ovf_in_reset", overflow, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        // Release while idle must be ignored
        buf_release = 1'b1;
        @(negedge clk);
        buf_release = 1'b0;
        @(negedge clk);
        chk("release_idle_ready", in_ready, 1);
        chk("release_idle_valid", msg_valid, 0);

        for (int v = 0; v < 5; v++) begin
            load_msg(vecs[v].msg_sel);
            model_reset();
            send(0, vecs[v].nbytes, vecs[v].with_last, vecs[v].toggle);
            chk($sformatf("v%0d_len", v), msg_length_byte, vecs[v].exp_len);
            chk($sformatf("v%0d_ovf", v), overflow, vecs[v].exp_ovf);
            chk($sformatf("v%0d_valid", v), msg_valid, 1);
            chk($sformatf("v%0d_ready", v), in_ready, 0);
            chk($sformatf("v%0d_probe", v), ct_flat[8*vecs[v].probe_idx +: 8], vecs[v].probe_val);
            drain_sb();
            tail_zero(vecs[v].exp_len);

            // Hammer the input while the message is held
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_byte  = 8'hFF;
                in_last  = k[0];
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk_buf($sformatf("v%0d_hold_frozen", v));
            chk($sformatf("v%0d_hold_len", v), msg_length_byte, vecs[v].exp_len);
            chk($sformatf("v%0d_hold_ovf", v), overflow, vecs[v].exp_ovf);
            chk($sformatf("v%0d_hold_valid", v), msg_valid, 1);

            release_and_clear(vecs[v].exp_len);
        end

        // Reset in the middle of a load, with in_valid held across release
        load_msg(0);
        model_reset();
        send(0, 20, 1'b0, 1'b0);
        load_msg(1);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = msg_buf[0];
        in_last  = 1'b0;
        reset    = 1'b0;
        #1;
        clear_exp();
        chk_buf("midload_reset_buf");
        chk("midload_reset_len", msg_length_byte, 0);
        chk("midload_reset_valid", msg_valid, 0);
        model_reset();
        sb_q.push_back({8'd0, msg_buf[0]});
        exp_mem[0] = msg_buf[0];
        m_idx = 1;
        @(negedge clk);
        reset = 1'b1;
        send(1, 29, 1'b1, 1'b0);
        chk("reload_len", msg_length_byte, 29);
        chk("reload_byte0", ct_flat[7:0], 8'h5A);
        chk("reload_ovf", overflow, 0);
        drain_sb();
        tail_zero(29);
        release_and_clear(29);

        // Reset in the middle of a clear
        load_msg(0);
        model_reset();
        send(0, 43, 1'b1, 1'b0);
        drain_sb();
        @(negedge clk);
        buf_release = 1'b1;
        @(negedge clk);
        buf_release = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        clear_exp();
        chk_buf("midclear_reset_buf");
        chk("midclear_reset_len", msg_length_byte, 0);
        chk("midclear_reset_valid", msg_valid, 0);
        chk("midclear_reset_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midclear_ready", in_ready, 1);
        model_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
